la_ctrl: RTL and testbench
==========================

LA_CTRL -- requirements
Module: la_ctrl

Interface
REQ-001 SHALL have parameter LEN_W, default 5, meaning the width of the capture-length field; it matches the 32-entry sample RAM.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port ARM, input, 1 bit: one-cycle request to start waiting for a trigger.
REQ-005 SHALL have port ABORT, input, 1 bit: cancels an armed or running capture.
REQ-006 SHALL have port TRIG, input, 1 bit: trigger qualifier from the probed logic.
REQ-007 SHALL have port LEN, input, LEN_W bits: number of samples to capture minus 1, sampled on the accepted ARM.
REQ-008 SHALL have port LA_WE, output, 1 bit: RAM write enable and datapath counter enable.
REQ-009 SHALL have port STS_CE, output, 1 bit: one-cycle load strobe for the datapath status register.
REQ-010 SHALL have port BUSY, output, 1 bit: high in ARMED or CAPTURE.
REQ-011 SHALL have port DONE, output, 1 bit: high in DONE state; the sample RAM is readable by address.
REQ-012 SHALL have port SCNT, output, LEN_W bits: number of samples written in the current capture.

Function
REQ-013 SHALL implement the states IDLE, ARMED, CAPTURE and DONE; all outputs are registered.
REQ-014 In IDLE or DONE, ARM=1 SHALL capture LEN into an internal register, clear SCNT and enter ARMED on the next edge.
REQ-015 ARM SHALL be ignored in ARMED and CAPTURE.
REQ-016 In ARMED, a trigger event (REQ-029/030) SHALL move the block to CAPTURE, with LA_WE=1 from the first CAPTURE cycle.
REQ-017 In CAPTURE, LA_WE SHALL be 1 every cycle, SCNT SHALL increment by 1 per cycle, and the capture SHALL last exactly latched LEN+1 cycles.
REQ-018 On the cycle in which SCNT equals the latched LEN, CAPTURE SHALL end: the next state is DONE, LA_WE=0 and STS_CE=1 for exactly one cycle.
REQ-019 LEN=0 SHALL give one write; LEN=31 SHALL give 32 writes, and SCNT SHALL stop at 31 with no wrap.
REQ-020 DONE SHALL hold until ARM or RESET; DONE=1, BUSY=0 and LA_WE=0 while in DONE.
REQ-021 ABORT=1 in ARMED or CAPTURE SHALL go to IDLE on the next edge, drop LA_WE, issue no STS_CE and hold SCNT.
REQ-022 ABORT SHALL win over a trigger event or the final sample in the same cycle.
REQ-023 ABORT in IDLE or DONE SHALL go to IDLE and clear DONE.
REQ-024 ARM and ABORT together in IDLE or DONE: ABORT SHALL win and the state is IDLE.
REQ-025 LA_WE SHALL never be asserted outside CAPTURE; STS_CE SHALL never be asserted outside the CAPTURE-to-DONE transition.
REQ-026 Latency SHALL be one cycle from the trigger event to the first LA_WE and one cycle from the last LA_WE to STS_CE.

Reset
REQ-027 RESET=1 at a clock edge SHALL force IDLE, LA_WE=0, STS_CE=0, BUSY=0, DONE=0, SCNT=0 and the latched LEN=0, from any state including mid-capture.
REQ-028 RESET SHALL have priority over ARM, ABORT and TRIG.

Configuration
REQ-029 With LA_CTRL_TRIG_EDGE_EN defined, the trigger event SHALL be a rising edge of TRIG: registered previous TRIG=0 and current TRIG=1. The TRIG history register SHALL be reset to 1, so a TRIG already high at arming does not fire.
REQ-030 Without LA_CTRL_TRIG_EDGE_EN, the trigger event SHALL be TRIG=1 in any ARMED cycle (level), and no history register SHALL exist.

Verification
REQ-031 Level build, LEN=7: ARM, then TRIG=1 three cycles later -> exactly 8 consecutive LA_WE cycles, SCNT 0..7, one STS_CE, then DONE=1 and BUSY=0.
REQ-032 LEN=31: full capture -> 32 LA_WE cycles, SCNT ends at 31, STS_CE once; a second ARM from DONE restarts with SCNT=0.
REQ-033 ABORT on the 4th CAPTURE cycle with LEN=15 -> LA_WE low the next cycle, state IDLE, no STS_CE, SCNT=3.
REQ-034 RESET asserted mid-capture, then ARM or TRIG asserted in the same cycle -> all outputs 0 the next cycle, state IDLE.
REQ-035 Edge build: TRIG held high before and during ARM -> stays ARMED; TRIG low then high -> capture starts one cycle after the rising edge.
REQ-036 LEN changed during CAPTURE (3 to 20) -> capture length stays 4 samples.

Source files
------------

// File: rtl/la_ctrl.sv
// Logic-analyser capture controller: arm, wait for trigger, write LEN+1 samples, then hold DONE.
// Optional macro LA_CTRL_TRIG_EDGE_EN selects a rising-edge trigger instead of a level trigger.
module la_ctrl #(
  parameter int LEN_W = 5
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ARM,
  input  logic             ABORT,
  input  logic             TRIG,
  input  logic [LEN_W-1:0] LEN,
  output logic             LA_WE,
  output logic             STS_CE,
  output logic             BUSY,
  output logic             DONE,
  output logic [LEN_W-1:0] SCNT
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] w_len_next;
  logic [LEN_W-1:0] r_scnt;
  logic [LEN_W-1:0] w_scnt_next;
  logic             r_la_we;
  logic             r_sts_ce;
  logic             r_busy;
  logic             r_done;
  logic             w_sts_ce_next;
  logic             w_trig_evt;

`ifdef LA_CTRL_TRIG_EDGE_EN
  // History starts high so a TRIG already asserted when arming is not an edge.
  logic r_trig_prev;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_trig_prev <= 1'b1;
    end else begin
      r_trig_prev <= TRIG;
    end
  end

  assign w_trig_evt = TRIG & ~r_trig_prev;
`else
  assign w_trig_evt = TRIG;
`endif

  always_comb begin
    w_state_next  = r_state;
    w_len_next    = r_len;
    w_scnt_next   = r_scnt;
    w_sts_ce_next = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (ABORT) begin
          w_state_next = S_IDLE;
        end else if (ARM) begin
          w_state_next = S_ARMED;
          w_len_next   = LEN;
          w_scnt_next  = '0;
        end
      end
      S_ARMED: begin
        if (ABORT) begin
          w_state_next = S_IDLE;
        end else if (w_trig_evt) begin
          w_state_next = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        // SCNT is the address of the sample being written this cycle.
        if (ABORT) begin
          w_state_next = S_IDLE;
        end else if (r_scnt == r_len) begin
          w_state_next  = S_DONE;
          w_sts_ce_next = 1'b1;
        end else begin
          w_scnt_next = r_scnt + LEN_W'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= S_IDLE;
      r_len    <= '0;
      r_scnt   <= '0;
      r_la_we  <= 1'b0;
      r_sts_ce <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_len    <= w_len_next;
      r_scnt   <= w_scnt_next;
      r_la_we  <= (w_state_next == S_CAPTURE);
      r_sts_ce <= w_sts_ce_next;
      r_busy   <= (w_state_next == S_ARMED) || (w_state_next == S_CAPTURE);
      r_done   <= (w_state_next == S_DONE);
    end
  end

  assign LA_WE  = r_la_we;
  assign STS_CE = r_sts_ce;
  assign BUSY   = r_busy;
  assign DONE   = r_done;
  assign SCNT   = r_scnt;

endmodule

// File: tb/tb_la_ctrl.sv
// Self-checking bench for la_ctrl: directed scenarios plus random traffic against a transaction-level model.
module tb_la_ctrl;

  localparam int LEN_W = 5;

  logic             CLK = 1'b0;
  logic             RESET = 1'b1;
  logic             ARM = 1'b0;
  logic             ABORT = 1'b0;
  logic             TRIG = 1'b0;
  logic [LEN_W-1:0] LEN = '0;
  logic             LA_WE;
  logic             STS_CE;
  logic             BUSY;
  logic             DONE;
  logic [LEN_W-1:0] SCNT;

  la_ctrl #(.LEN_W(LEN_W)) dut (
    .CLK(CLK), .RESET(RESET), .ARM(ARM), .ABORT(ABORT), .TRIG(TRIG), .LEN(LEN),
    .LA_WE(LA_WE), .STS_CE(STS_CE), .BUSY(BUSY), .DONE(DONE), .SCNT(SCNT)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;

  // Model: a capture is "waiting", "writing" (with samples left) or "finished".
  bit m_waiting, m_writing, m_finished, m_strobe, m_prev_trig;
  int m_len, m_left, m_addr;
  int we_seen, sts_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc_n, obs, exp);
    end
  endtask

  task automatic model_step();
    bit evt;
`ifdef LA_CTRL_TRIG_EDGE_EN
    evt = TRIG && !m_prev_trig;
`else
    evt = TRIG;
`endif
    m_prev_trig = TRIG;
    m_strobe = 0;
    if (RESET) begin
      m_waiting = 0; m_writing = 0; m_finished = 0;
      m_len = 0; m_addr = 0; m_left = 0; m_prev_trig = 1;
    end else if ((m_waiting || m_writing) && ABORT) begin
      m_waiting = 0; m_writing = 0;
    end else if (m_writing) begin
      m_left--;
      if (m_left == 0) begin
        m_writing = 0; m_finished = 1; m_strobe = 1;
        $display("capture complete: %0d samples, cycle %0d", m_len + 1, cyc_n);
      end else begin
        m_addr++;
      end
    end else if (m_waiting) begin
      if (evt) begin
        m_waiting = 0; m_writing = 1; m_left = m_len + 1;
      end
    end else if (ABORT) begin
      m_finished = 0;
    end else if (ARM) begin
      m_waiting = 1; m_finished = 0; m_len = int'(LEN); m_addr = 0;
    end
  endtask

  task automatic compare_all();
    check("la_we", {31'b0, LA_WE}, {31'b0, m_writing});
    check("sts_ce", {31'b0, STS_CE}, {31'b0, m_strobe});
    check("busy", {31'b0, BUSY}, {31'b0, m_waiting || m_writing});
    check("done", {31'b0, DONE}, {31'b0, m_finished});
    check("scnt", {27'b0, SCNT}, m_addr);
  endtask

  task automatic cyc(input logic rst, input logic arm, input logic abort,
                     input logic trig, input logic [LEN_W-1:0] len);
    @(negedge CLK);
    RESET = rst; ARM = arm; ABORT = abort; TRIG = trig; LEN = len;
    @(posedge CLK);
    cyc_n++;
    model_step();
    #1;
    compare_all();
    if (LA_WE) we_seen++;
    if (STS_CE) sts_seen++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 5'd0);
  endtask

  initial begin
    m_prev_trig = 1;
    cyc(1, 0, 0, 0, 5'd0);
    cyc(1, 1, 0, 1, 5'd9);
    check("reset_state", {24'b0, LA_WE, STS_CE, BUSY, DONE, SCNT}, 32'd0);

    // Level-style capture of 8 samples, trigger three cycles after ARM.
    we_seen = 0; sts_seen = 0;
    cyc(0, 1, 0, 0, 5'd7);
    idle(2);
    cyc(0, 0, 0, 1, 5'd0);
    idle(12);
    check("len7_writes", we_seen, 8);
    check("len7_strobes", sts_seen, 1);
    check("len7_done", {30'b0, DONE, BUSY}, 32'd2);
    check("len7_scnt", {27'b0, SCNT}, 7);
    $display("scenario len7: writes=%0d strobes=%0d", we_seen, sts_seen);

    // Full-depth capture, then re-arm from DONE.
    we_seen = 0; sts_seen = 0;
    cyc(0, 1, 0, 0, 5'd31);
    cyc(0, 0, 0, 1, 5'd0);
    idle(40);
    check("len31_writes", we_seen, 32);
    check("len31_strobes", sts_seen, 1);
    check("len31_scnt", {27'b0, SCNT}, 31);
    cyc(0, 1, 0, 0, 5'd2);
    check("rearm_scnt", {27'b0, SCNT}, 0);
    check("rearm_busy", {31'b0, BUSY}, 1);
    idle(3);
    $display("scenario len31: writes=%0d strobes=%0d", we_seen, sts_seen);

    // Abort on the 4th capture cycle.
    cyc(0, 0, 1, 0, 5'd0);
    sts_seen = 0;
    cyc(0, 1, 0, 0, 5'd15);
    cyc(0, 0, 0, 1, 5'd0);
    idle(3);
    cyc(0, 0, 1, 0, 5'd0);
    check("abort_we", {31'b0, LA_WE}, 0);
    check("abort_busy", {30'b0, BUSY, DONE}, 0);
    check("abort_scnt", {27'b0, SCNT}, 3);
    idle(3);
    check("abort_strobes", sts_seen, 0);
    $display("scenario abort: scnt=%0d", SCNT);

    // Reset mid-capture with ARM and TRIG in the same cycle.
    cyc(0, 1, 0, 0, 5'd10);
    cyc(0, 0, 0, 1, 5'd0);
    idle(3);
    cyc(1, 1, 0, 1, 5'd12);
    check("rst_mid_outputs", {24'b0, LA_WE, STS_CE, BUSY, DONE, SCNT}, 0);
    idle(2);
    $display("scenario reset mid-capture");

    // TRIG held high across ARM.
    cyc(0, 0, 0, 1, 5'd0);
    cyc(0, 1, 0, 1, 5'd4);
    cyc(0, 0, 0, 1, 5'd0);
    cyc(0, 0, 0, 1, 5'd0);
`ifdef LA_CTRL_TRIG_EDGE_EN
    check("edge_held_we", {30'b0, LA_WE, BUSY}, 32'd1);
    cyc(0, 0, 0, 0, 5'd0);
    cyc(0, 0, 0, 1, 5'd0);
    check("edge_rise_we", {31'b0, LA_WE}, 1);
`else
    check("level_held_we", {30'b0, LA_WE, BUSY}, 32'd3);
`endif
    idle(10);
    cyc(0, 0, 1, 0, 5'd0);
    $display("scenario trigger held across ARM");

    // LEN changes during capture must not alter the latched length.
    we_seen = 0;
    cyc(0, 1, 0, 0, 5'd3);
    cyc(0, 0, 0, 1, 5'd3);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 5'd20);
    check("lenchg_writes", we_seen, 4);
    $display("scenario LEN change: writes=%0d", we_seen);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0,
          LEN_W'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
